sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; successor to the fixed 14-bit/16-deep buffer.
//  Adds occupancy count, programmable almost-full/almost-empty, and sticky
//  overflow/underflow error flags. Optional first-word-fall-through (FWFT) read mode.
//  Sits between same-clock producer/consumer stages on the data path.
// PARAMETERS
//  DATA_W     14   data word width (bits)
//  ADDR_W     4    address width; DEPTH = 2**ADDR_W words (16)
//  AFULL_TH   12   almost_full asserted when count >= AFULL_TH (1..DEPTH)
//  AEMPTY_TH  2    almost_empty asserted when count <= AEMPTY_TH (0..DEPTH-1)
// PORTS
//  clk          in   1         single clock, rising edge
//  rst          in   1         asynchronous reset, active-high
//  data_in      in   DATA_W    write data
//  w_en         in   1         write request
//  r_en         in   1         read request
//  clr_err      in   1         clears overflow/underflow
//  data_out     out  DATA_W    read data
//  valid_out    out  1         data_out holds a popped/head word
//  full         out  1         count == DEPTH
//  empty        out  1         count == 0
//  almost_full  out  1         count >= AFULL_TH
//  almost_empty out  1         count <= AEMPTY_TH
//  count        out  ADDR_W+1  words held, 0..DEPTH
//  overflow     out  1         sticky: write attempted while full
//  underflow    out  1         sticky: read attempted while empty
// BEHAVIOUR
//  Reset (async, rst=1): wptr=rptr=0, count=0, empty=1, almost_empty=1, full=0,
//   almost_full=0, data_out=0, valid_out=0, overflow=underflow=0. RAM not reset.
//   Reset mid-operation discards all contents; first post-reset write lands at addr 0.
//  Pointers: ADDR_W+1 bits, MSB is wrap bit. full = MSBs differ, low bits equal.
//   empty = pointers equal. count = wptr - rptr mod 2**(ADDR_W+1).
//   Flags/count derive only from registered pointers (no input-to-flag comb paths).
//  Accept: wr_ok = w_en & ~full; rd_ok = r_en & ~empty (state at current edge).
//   Full + w_en + r_en: read accepted, write rejected, overflow set.
//   Empty + w_en + r_en: write accepted, read rejected, underflow set.
//   Both accepted: count unchanged, both pointers advance, wrap at DEPTH.
//  Default read: rd_ok at edge N -> data_out = mem[rptr], valid_out=1 after edge N.
//   No rd_ok at an edge -> data_out <= 0, valid_out <= 0 (zero-when-idle convention).
//  Errors: overflow <= 1 on w_en&full; underflow <= 1 on r_en&empty; clr_err clears;
//   a new event in the same cycle as clr_err wins (flag stays 1).
// CONFIGURATION
//  SYNC_FIFO_FWFT_EN defined: data_out = mem[rptr] combinationally, valid_out = ~empty;
//   r_en acts as pop-acknowledge of the displayed word. Write into empty FIFO at edge N ->
//   word on data_out, valid_out=1 after edge N. data_out is don't-care (not zeroed) when
//   empty. Flag, count and error rules unchanged.
//  Undefined: default registered-read behaviour above, one-cycle read latency.
// STRUCTURE
//  sync_fifo_pkg: ptr/count typedefs parametrised via localparams, DEPTH function,
//   threshold range-check function used by elaboration-time assertions.
//  Sub-module sync_fifo_ram: DEPTH x DATA_W, synchronous write on clk when wr_ok,
//   asynchronous read at rptr; no reset. Top holds pointers, flags, output stage.
// TESTING
//  T1 reset: assert rst mid-stream with count=5 -> all outputs at reset values
//   immediately; write 0x0AA after release -> read returns 0x0AA.
//  T2 fill/drain: 16 writes 1..16 -> full=1, count=16, almost_full from 12th write;
//   16 reads -> data_out 1..16 in order, one cycle after each read; empty=1 at end.
//  T3 full boundary: full, w_en=r_en=1 with data_in=0x3FF -> read accepted, 0x3FF
//   dropped, count=15, overflow=1; clr_err=1 one cycle -> overflow=0.
//  T4 empty boundary: empty, w_en=r_en=1 with 0x123 -> count=1, underflow=1,
//   data_out=0, valid_out=0; next read -> data_out=0x123.
//  T5 wrap: 40 cycles of simultaneous write/read at count=3 -> count stays 3, data
//   order preserved across pointer wrap, no flags change.
//  T6 FWFT build: write 0x055 into empty -> next cycle data_out=0x055, valid_out=1
//   without r_en; r_en=1 -> empty=1, valid_out=0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared sizing for the parametrised single-clock FIFO: default geometry, pointer/count types,
// depth and threshold range-check helpers used at elaboration.
package sync_fifo_pkg;

    localparam int DEF_DATA_W    = 14;
    localparam int DEF_ADDR_W    = 4;
    localparam int DEF_AFULL_TH  = 12;
    localparam int DEF_AEMPTY_TH = 2;

    // Pointers carry one extra wrap bit; count spans 0..DEPTH inclusive.
    typedef logic [DEF_ADDR_W:0] ptr_t;
    typedef logic [DEF_ADDR_W:0] count_t;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic bit th_in_range(input int th, input int lo, input int hi);
        return (th >= lo) && (th <= hi);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: DEPTH x DATA_W, synchronous write, asynchronous read, contents not reset.
module sync_fifo_ram #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, almost-full/empty and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise one-cycle registered read.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int AFULL_TH  = DEF_AFULL_TH,
    parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              w_en,
    input  logic              r_en,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = fifo_depth(ADDR_W);
    localparam logic [ADDR_W:0] AF_LIM = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AE_LIM = (ADDR_W+1)'(AEMPTY_TH);

    if (!th_in_range(AFULL_TH, 1, DEPTH)) begin : g_bad_afull
        $error("sync_fifo_param: AFULL_TH out of range 1..DEPTH");
    end
    if (!th_in_range(AEMPTY_TH, 0, DEPTH - 1)) begin : g_bad_aempty
        $error("sync_fifo_param: AEMPTY_TH out of range 0..DEPTH-1");
    end

    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic [DATA_W-1:0] rdata;
    logic              wr_ok;
    logic              rd_ok;

    // All status derives from registered pointers, so no input reaches a flag combinationally.
    assign count        = wptr - rptr;
    assign empty        = (wptr == rptr);
    assign full         = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                          (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign almost_full  = (count >= AF_LIM);
    assign almost_empty = (count <= AE_LIM);

    assign wr_ok = w_en & ~full;
    assign rd_ok = r_en & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
        end
    end

    // A fresh error event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (w_en & full)  | (overflow  & ~clr_err);
            underflow <= (r_en & empty) | (underflow & ~clr_err);
        end
    end

    sync_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wptr[ADDR_W-1:0]),
        .wdata (data_in),
        .raddr (rptr[ADDR_W-1:0]),
        .rdata (rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out  = rdata;
    assign valid_out = ~empty;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            data_out  <= rd_ok ? rdata : '0;
            valid_out <= rd_ok;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed + randomized bench for sync_fifo_param against a queue-based reference model.
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] data_in = '0;
    logic        w_en = 1'b0;
    logic        r_en = 1'b0;
    logic        clr_err = 1'b0;
    logic [13:0] data_out;
    logic        valid_out;
    logic        full, empty, almost_full, almost_empty;
    logic [4:0]  count;
    logic        overflow, underflow;

    int checks   = 0;
    int failures = 0;

    logic [13:0] q[$];
    bit          m_ovf = 0;
    bit          m_udf = 0;
    logic [13:0] m_dout = '0;
    bit          m_vld = 0;

    always #5 clk = ~clk;

    sync_fifo_param dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .w_en         (w_en),
        .r_en         (r_en),
        .clr_err      (clr_err),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, ".count"},        32'(count),        32'(n));
        check({tag, ".full"},         32'(full),         32'(n == 16));
        check({tag, ".empty"},        32'(empty),        32'(n == 0));
        check({tag, ".almost_full"},  32'(almost_full),  32'(n >= 12));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= 2));
        check({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
        check({tag, ".underflow"},    32'(underflow),    32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
        check({tag, ".valid_out"},    32'(valid_out),    32'(n != 0));
        if (n != 0) check({tag, ".data_out"}, 32'(data_out), 32'(q[0]));
`else
        check({tag, ".valid_out"},    32'(valid_out),    32'(m_vld));
        check({tag, ".data_out"},     32'(data_out),     32'(m_dout));
`endif
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 0;
        m_udf  = 0;
        m_dout = '0;
        m_vld  = 0;
    endtask

    // One clock: drive after a falling edge, update the model at the rising edge, check at the next fall.
    task automatic step(input bit w, input bit r, input logic [13:0] d, input bit c, input string tag);
        int  n;
        bit  f, e;
        w_en    = w;
        r_en    = r;
        data_in = d;
        clr_err = c;
        @(posedge clk);
        n = q.size();
        f = (n == 16);
        e = (n == 0);
        m_ovf = (w && f) || (m_ovf && !c);
        m_udf = (r && e) || (m_udf && !c);
        if (r && !e) begin
            m_dout = q.pop_front();
            m_vld  = 1;
        end else begin
            m_dout = '0;
            m_vld  = 0;
        end
        if (w && !f) q.push_back(d);
        @(negedge clk);
        w_en    = 1'b0;
        r_en    = 1'b0;
        clr_err = 1'b0;
        check_all(tag);
    endtask

    initial begin
        // Reset state
        #1;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // T1: asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) step(1, 0, 14'($urandom), 0, "t1_fill");
        rst = 1'b1;
        #1;
        model_reset();
        check_all("t1_rst");
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 14'h0AA, 0, "t1_w");
`ifdef SYNC_FIFO_FWFT_EN
        check("t1_fwft_data", 32'(data_out), 32'h0AA);
        step(0, 1, 14'h0, 0, "t1_r");
`else
        step(0, 1, 14'h0, 0, "t1_r");
        check("t1_data", 32'(data_out), 32'h0AA);
`endif

        // T2: fill with 1..16 then drain in order
        for (int i = 1; i <= 16; i++) step(1, 0, 14'(i), 0, "t2_fill");
        check("t2_full", 32'(full), 32'd1);
        for (int i = 1; i <= 16; i++) step(0, 1, 14'h0, 0, "t2_drain");
        check("t2_empty", 32'(empty), 32'd1);

        // T3: simultaneous write/read while full
        for (int i = 0; i < 16; i++) step(1, 0, 14'($urandom), 0, "t3_fill");
        step(1, 1, 14'h3FF, 0, "t3_both");
        check("t3_count", 32'(count), 32'd15);
        check("t3_ovf", 32'(overflow), 32'd1);
        step(0, 0, 14'h0, 1, "t3_clr");

        // T4: simultaneous write/read while empty
        while (q.size() != 0) step(0, 1, 14'h0, 0, "t4_drain");
        step(1, 1, 14'h123, 0, "t4_both");
        check("t4_udf", 32'(underflow), 32'd1);
        step(0, 1, 14'h0, 0, "t4_rd");
        step(0, 0, 14'h0, 1, "t4_clr");

        // T5: steady-state streaming across pointer wrap
        for (int i = 0; i < 3; i++) step(1, 0, 14'($urandom), 0, "t5_prime");
        for (int i = 0; i < 40; i++) step(1, 1, 14'($urandom), 0, "t5_stream");
        check("t5_count", 32'(count), 32'd3);

        // Randomized traffic: fill-biased then drain-biased
        for (int i = 0; i < 300; i++)
            step(($urandom % 4) != 0, ($urandom % 3) == 0, 14'($urandom), ($urandom % 16) == 0, "rnd_fill");
        for (int i = 0; i < 300; i++)
            step(($urandom % 3) == 0, ($urandom % 4) != 0, 14'($urandom), ($urandom % 16) == 0, "rnd_drain");

`ifdef SYNC_FIFO_FWFT_EN
        // T6: first word falls through without a read
        while (q.size() != 0) step(0, 1, 14'h0, 0, "t6_drain");
        step(1, 0, 14'h055, 0, "t6_w");
        check("t6_data", 32'(data_out), 32'h055);
        check("t6_valid", 32'(valid_out), 32'd1);
        step(0, 1, 14'h0, 0, "t6_pop");
        check("t6_empty", 32'(empty), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
